// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI flash read engine: FSM state codes,
// command/geometry constants, IO-enable encodings and a byte-swap helper.
package qspi_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_CMD   = 3'd1;
    localparam state_t ST_ADDR  = 3'd2;
    localparam state_t ST_DUMMY = 3'd3;
    localparam state_t ST_DATA  = 3'd4;
    localparam state_t ST_DONE  = 3'd5;
    localparam state_t ST_GAP   = 3'd6;

    localparam logic [7:0] QSPI_CMD_QOFR     = 8'h6B;
    localparam int         QSPI_ADDR_BITS    = 24;
    localparam int         QSPI_DATA_NIBBLES = 8;

    localparam logic [3:0] OE_SINGLE = 4'b0001;
    localparam logic [3:0] OE_NONE   = 4'b0000;

    // Nibbles arrive byte0-first, so the shift register ends up big-endian;
    // the response word is little-endian (byte0 in [7:0]).
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/qspi_sck_gen.sv
// SCK divider: CLK_DIV soc_clk cycles per half-period, always starting low.
// rise/fall are single-cycle strobes asserted in the cycle whose closing
// edge toggles sck, so the FSM can act on the very edge SCK moves.
module qspi_sck_gen
    import qspi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic soc_clk,
    input  logic rst_n,
    input  logic en,
    input  logic start_low,
    output logic sck,
    output logic rise,
    output logic fall
);

    logic [3:0] div_cnt;
    logic       half_end;

    assign half_end = en && (div_cnt == 4'(CLK_DIV - 1));
    assign rise     = half_end && !sck;
    assign fall     = half_end && sck;

    // Half-period counter; disabled or restarted means SCK parked low.
    always_ff @(posedge soc_clk) begin
        if (!rst_n || start_low || !en) begin
            sck     <= 1'b0;
            div_cnt <= '0;
        end else if (half_end) begin
            sck     <= ~sck;
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/qspi_flash_reader.sv
// Quad Output Fast Read engine: one 24-bit address in, one 32-bit word out.
// Command and address go out serially on IO0, dummy and data phases leave
// all IOs tristated, data comes back one nibble per SCK rising edge.
module qspi_flash_reader
    import qspi_pkg::*;
#(
    parameter int         CLK_DIV      = 2,
    parameter int         CSB_HIGH     = 4,
    parameter int         DUMMY_CYCLES = 8,
    parameter logic [7:0] READ_CMD     = QSPI_CMD_QOFR
) (
    input  logic        soc_clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [23:0] req_addr,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        busy,
    output logic        qspi_csb,
    output logic        qspi_clk,
    output logic [3:0]  qspi_oe,
    output logic [3:0]  qspi_dout,
    input  logic [3:0]  qspi_din
);

    localparam int HW = $clog2(CSB_HIGH + 1);

    state_t        state;
    logic [5:0]    bit_cnt;
    logic [5:0]    phase_len;
    logic [HW-1:0] hi_cnt;
    logic [31:0]   sh_out;
    logic [31:0]   sh_in;
    logic          accept;
    logic          sck_en;
    logic          sck_rise;
    logic          sck_fall;
    logic          phase_end;
    logic          gap_met;

    // hi_cnt counts completed CSB-high cycles; it rests saturated in IDLE,
    // which is why it comes out of reset preloaded.
    assign gap_met   = hi_cnt >= HW'(CSB_HIGH);
    assign req_ready = (state == ST_IDLE || state == ST_GAP) && gap_met;
    assign accept    = req_valid && req_ready;
    assign busy      = !(state == ST_IDLE || state == ST_GAP);
    assign sck_en    = (state == ST_CMD) || (state == ST_ADDR) ||
                       (state == ST_DUMMY) || (state == ST_DATA);

    qspi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
        .soc_clk   (soc_clk),
        .rst_n     (rst_n),
        .en        (sck_en),
        .start_low (accept),
        .sck       (qspi_clk),
        .rise      (sck_rise),
        .fall      (sck_fall)
    );

    // Number of SCK periods in the current phase.
    always_comb begin
        phase_len = 6'd8;
        case (state)
            ST_ADDR:  phase_len = 6'(QSPI_ADDR_BITS);
            ST_DUMMY: phase_len = 6'(DUMMY_CYCLES);
            ST_DATA:  phase_len = 6'(QSPI_DATA_NIBBLES);
            default:  phase_len = 6'd8;
        endcase
    end

    // Phases end on a falling strobe so each one closes with SCK low.
    assign phase_end = sck_fall && (bit_cnt == phase_len - 6'd1);

    // Transaction FSM, shifters and pin registers; outputs move only on
    // CSB assert or SCK falling edges.
    always_ff @(posedge soc_clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            hi_cnt     <= HW'(CSB_HIGH);
            sh_out     <= '0;
            sh_in      <= '0;
            qspi_csb   <= 1'b1;
            qspi_oe    <= OE_NONE;
            qspi_dout  <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_GAP: begin
                    if (accept) begin
                        state     <= ST_CMD;
                        bit_cnt   <= '0;
                        qspi_csb  <= 1'b0;
                        qspi_oe   <= OE_SINGLE;
                        qspi_dout <= {3'b000, READ_CMD[7]};
                        sh_out    <= {READ_CMD[6:0], req_addr, 1'b0};
                        sh_in     <= '0;
                    end else if (state == ST_GAP) begin
                        if (gap_met) state <= ST_IDLE;
                        else         hi_cnt <= hi_cnt + HW'(1);
                    end
                end
                ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
                    if (sck_rise && state == ST_DATA)
                        sh_in <= {sh_in[27:0], qspi_din};
                    if (sck_fall) begin
                        bit_cnt <= phase_end ? 6'd0 : bit_cnt + 6'd1;
                        // Command and address form one continuous 32-bit stream.
                        if (state == ST_CMD || (state == ST_ADDR && !phase_end)) begin
                            qspi_dout <= {3'b000, sh_out[31]};
                            sh_out    <= {sh_out[30:0], 1'b0};
                        end
                        if (phase_end) begin
                            case (state)
                                ST_CMD: state <= ST_ADDR;
                                ST_ADDR: begin
                                    state     <= (DUMMY_CYCLES == 0) ? ST_DATA : ST_DUMMY;
                                    qspi_oe   <= OE_NONE;
                                    qspi_dout <= '0;
                                end
                                ST_DUMMY: state <= ST_DATA;
                                default: begin
                                    state      <= ST_DONE;
                                    qspi_csb   <= 1'b1;
                                    resp_valid <= 1'b1;
                                    resp_data  <= bswap32(sh_in);
                                end
                            endcase
                        end
                    end
                end
                ST_DONE: begin
                    // The DONE cycle itself already had CSB high.
                    state  <= ST_GAP;
                    hi_cnt <= HW'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_flash_reader.sv
// Directed bench: instance 0 at CLK_DIV=2, instance 1 at CLK_DIV=1, each
// with a behavioural Quad-Output flash that records IO0 and drives nibbles.
module tb_qspi_flash_reader;

    logic             soc_clk;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0][23:0] req_addr;
    logic [1:0]       req_ready;
    logic [1:0]       resp_valid;
    logic [1:0][31:0] resp_data;
    logic [1:0]       busy;
    logic [1:0]       csb;
    logic [1:0]       sck;
    logic [1:0][3:0]  oe;
    logic [1:0][3:0]  dout;
    logic [1:0][3:0]  din;

    logic [7:0] fl_bytes [4];

    int checks = 0;
    int errors = 0;

    qspi_flash_reader #(.CLK_DIV(2), .CSB_HIGH(4), .DUMMY_CYCLES(8), .READ_CMD(8'h6B)) dut2 (
        .soc_clk(soc_clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_addr(req_addr[0]),
        .req_ready(req_ready[0]), .resp_valid(resp_valid[0]), .resp_data(resp_data[0]),
        .busy(busy[0]), .qspi_csb(csb[0]), .qspi_clk(sck[0]), .qspi_oe(oe[0]),
        .qspi_dout(dout[0]), .qspi_din(din[0])
    );

    qspi_flash_reader #(.CLK_DIV(1), .CSB_HIGH(4), .DUMMY_CYCLES(8), .READ_CMD(8'h6B)) dut1 (
        .soc_clk(soc_clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_addr(req_addr[1]),
        .req_ready(req_ready[1]), .resp_valid(resp_valid[1]), .resp_data(resp_data[1]),
        .busy(busy[1]), .qspi_csb(csb[1]), .qspi_clk(sck[1]), .qspi_oe(oe[1]),
        .qspi_dout(dout[1]), .qspi_din(din[1])
    );

    initial begin
        soc_clk = 1'b0;
        forever #5 soc_clk = ~soc_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    // Flash models: count SCK rises while selected, capture IO0 on edges
    // 1..32, check OE, and present data nibble n before rise 40+n.
    for (genvar g = 0; g < 2; g++) begin : g_flash
        int          edge_cnt = 0;
        int          last_edges = 0;
        int          oe_err = 0;
        logic [7:0]  cmd_sh = '0;
        logic [23:0] addr_sh = '0;
        logic [3:0]  din_r = '0;
        logic [2:0]  idx;
        logic [7:0]  b;
        assign din[g] = din_r;
        always @(posedge sck[g] or posedge csb[g]) begin
            if (csb[g]) begin
                last_edges = edge_cnt;
                edge_cnt   = 0;
                din_r      = '0;
            end else begin
                edge_cnt++;
                if (edge_cnt <= 8)       cmd_sh  = {cmd_sh[6:0], dout[g][0]};
                else if (edge_cnt <= 32) addr_sh = {addr_sh[22:0], dout[g][0]};
                if (oe[g] !== ((edge_cnt <= 32) ? 4'b0001 : 4'b0000)) oe_err++;
                if (edge_cnt >= 40 && edge_cnt < 48) begin
                    idx   = 3'(edge_cnt - 40);
                    b     = fl_bytes[idx[2:1]];
                    din_r = idx[0] ? b[3:0] : b[7:4];
                end else begin
                    din_r = '0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs from the accept cycle until resp_valid (or the limit); checks the
    // SCK waveform against the divider and snapshots the first busy cycle.
    task automatic wait_resp(input int d, input int div, input bit hold, input int limit,
                             output int lat, output int sck_bad, output logic [7:0] first);
        lat = -1; sck_bad = 0; first = '0;
        for (int k = 1; k <= limit; k++) begin
            @(posedge soc_clk); #1;
            if (k == 1) begin
                first = {csb[d], sck[d], busy[d], req_ready[d], oe[d]};
                if (!hold) req_valid[d] = 1'b0;
            end
            if (k <= 96 * div && sck[d] !== 1'(((k - 1) / div) % 2)) sck_bad++;
            if (resp_valid[d]) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat, sb, j_rdy, csb_bad, nresp;
        logic [7:0] first;

        rst_n = 1'b0;
        req_valid = '0;
        req_addr = '0;
        fl_bytes = '{8'h00, 8'h00, 8'h00, 8'h00};
        repeat (3) @(posedge soc_clk);
        #1 rst_n = 1'b1;

        // Idle after reset: {csb, sck, oe, ready, valid, busy}
        for (int i = 0; i < 20; i++) begin
            @(posedge soc_clk); #1;
            chk("reset_idle", 32'({csb[0], sck[0], oe[0], req_ready[0], resp_valid[0], busy[0]}),
                32'(9'b1_0_0000_1_0_0));
        end
        chk("reset_data", resp_data[0], 32'h0);

        // Single read at CLK_DIV=2
        fl_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        req_addr[0] = 24'h001234;
        req_valid[0] = 1'b1;
        wait_resp(0, 2, 1'b0, 400, lat, sb, first);
        chk("r1_first", 32'(first), 32'h21);
        chk("r1_latency", 32'(lat), 32'd193);
        chk("r1_data", resp_data[0], 32'hDEADBEEF);
        chk("r1_csb_busy_valid", 32'({csb[0], busy[0], resp_valid[0]}), 32'b111);
        chk("r1_sck_wave", 32'(sb), 32'd0);
        chk("r1_cmd", 32'(g_flash[0].cmd_sh), 32'h6B);
        chk("r1_addr", 32'(g_flash[0].addr_sh), 32'h001234);
        chk("r1_edges", 32'(g_flash[0].last_edges), 32'd48);
        @(posedge soc_clk); #1;
        chk("r1_pulse_single", 32'(resp_valid[0]), 32'd0);
        @(posedge soc_clk); #1;
        chk("r1_after_busy_ready", 32'({busy[0], req_ready[0]}), 32'b00);
        chk("r1_data_hold", resp_data[0], 32'hDEADBEEF);
        repeat (10) @(posedge soc_clk);
        #1;

        // Back-to-back with req_valid held high
        fl_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        req_addr[0] = 24'hC0FFEE;
        req_valid[0] = 1'b1;
        wait_resp(0, 2, 1'b1, 400, lat, sb, first);
        chk("b1_latency", 32'(lat), 32'd193);
        chk("b1_data", resp_data[0], 32'h44332211);
        chk("b1_addr", 32'(g_flash[0].addr_sh), 32'hC0FFEE);
        chk("b1_csb_done", 32'(csb[0]), 32'd1);
        req_addr[0] = 24'h5A5A5A;
        j_rdy = -1; csb_bad = 0;
        for (int j = 1; j <= 20; j++) begin
            @(posedge soc_clk); #1;
            if (!csb[0]) csb_bad++;
            if (req_ready[0]) begin
                j_rdy = j;
                break;
            end
        end
        chk("b2_accept_gap", 32'(j_rdy), 32'd4);
        chk("b2_csb_high", 32'(csb_bad), 32'd0);
        wait_resp(0, 2, 1'b0, 400, lat, sb, first);
        chk("b2_first", 32'(first), 32'h21);
        chk("b2_latency", 32'(lat), 32'd193);
        chk("b2_data", resp_data[0], 32'h44332211);
        chk("b2_addr", 32'(g_flash[0].addr_sh), 32'h5A5A5A);
        repeat (10) @(posedge soc_clk);
        #1;

        // Reset pulse in the ADDR phase, then a clean read
        req_addr[0] = 24'h000FFF;
        req_valid[0] = 1'b1;
        @(posedge soc_clk); #1;
        req_valid[0] = 1'b0;
        repeat (59) @(posedge soc_clk);
        #1 rst_n = 1'b0;
        @(posedge soc_clk); #1;
        chk("rst_mid_pins", 32'({csb[0], sck[0], oe[0], dout[0], resp_valid[0], req_ready[0], busy[0]}),
            32'(13'b1_0_0000_0000_0_1_0));
        rst_n = 1'b1;
        nresp = 0;
        for (int i = 0; i < 250; i++) begin
            @(posedge soc_clk); #1;
            if (resp_valid[0]) nresp++;
        end
        chk("rst_mid_no_resp", 32'(nresp), 32'd0);
        fl_bytes = '{8'h01, 8'h23, 8'h45, 8'h67};
        req_addr[0] = 24'h765432;
        req_valid[0] = 1'b1;
        wait_resp(0, 2, 1'b0, 400, lat, sb, first);
        chk("rst_after_latency", 32'(lat), 32'd193);
        chk("rst_after_data", resp_data[0], 32'h67452301);
        chk("rst_after_addr", 32'(g_flash[0].addr_sh), 32'h765432);
        chk("div2_oe_profile", 32'(g_flash[0].oe_err), 32'd0);
        repeat (5) @(posedge soc_clk);
        #1;

        // CLK_DIV=1 instance
        fl_bytes = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};
        req_addr[1] = 24'hFEDCBA;
        req_valid[1] = 1'b1;
        wait_resp(1, 1, 1'b0, 200, lat, sb, first);
        chk("d1_first", 32'(first), 32'h21);
        chk("d1_latency", 32'(lat), 32'd97);
        chk("d1_data", resp_data[1], 32'h3CC35AA5);
        chk("d1_sck_wave", 32'(sb), 32'd0);
        chk("d1_cmd", 32'(g_flash[1].cmd_sh), 32'h6B);
        chk("d1_addr", 32'(g_flash[1].addr_sh), 32'hFEDCBA);
        chk("d1_edges", 32'(g_flash[1].last_edges), 32'd48);
        chk("d1_oe_profile", 32'(g_flash[1].oe_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qspi_flash_reader.md
Name: qspi_flash_reader

Overview:
- Hardware QSPI read engine for the external boot/XIP flash. It generates the CSB, SCK and IO[3:0] pin signals that the pad mux selects whenever the GPIO block hands a pin back to hardware control (master_control bit = 0, flash_control bit = 0).
- It accepts one 24-bit byte-address read request at a time and issues a Quad Output Fast Read (0x6B).
- It returns one 32-bit word to the fetch/MMIO side.

Parameters:
- CLK_DIV, 2: soc_clk cycles per SCK half-period. Legal values are 1..15.
- CSB_HIGH, 4: minimum soc_clk cycles CSB stays high between transactions. Must be at least 1.
- DUMMY_CYCLES, 8: SCK cycles between the address and data phases.
- READ_CMD, 8'h6B: command byte sent in the command phase.

Ports:
- soc_clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset, sampled on posedge soc_clk.
- req_valid  in  1  read request.
- req_addr  in  24  flash byte address. Captured on accept; no alignment requirement.
- req_ready  out  1  engine idle and CSB_HIGH satisfied.
- resp_valid  out  1  single-cycle pulse; resp_data is valid in that cycle.
- resp_data  out  32  returned word, little-endian: the first flash byte lands in [7:0].
- busy  out  1  high from accept until the cycle after resp_valid.
- qspi_csb  out  1  chip select, active low.
- qspi_clk  out  1  SCK, SPI mode 0 (idles low).
- qspi_oe  out  4  per-IO output enable.
- qspi_dout  out  4  per-IO output data.
- qspi_din  in  4  per-IO input data from the pads.

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_data=0, busy=0, qspi_csb=1, qspi_clk=0, qspi_oe=0, qspi_dout=0. The CSB-high counter is preloaded so that req_ready=1 immediately after reset.
- Reset mid-transaction: on the next posedge all outputs return to their reset values, no resp_valid is issued, and the captured address/data are discarded.
- Accept: when req_valid && req_ready, req_addr is captured. req_ready and busy change in the cycle after accept. While busy, req_valid is ignored.
- FSM states and transitions:
  - IDLE -> CMD on accept.
  - CMD -> ADDR after 8 SCK cycles.
  - ADDR -> DUMMY after 24 SCK cycles.
  - DUMMY -> DATA after DUMMY_CYCLES SCK cycles.
  - DATA -> DONE after 8 SCK cycles.
  - DONE -> GAP.
  - GAP -> IDLE after CSB_HIGH cycles with CSB high.
- SCK generation:
  - qspi_csb=0 from cycle accept+1.
  - Each SCK period is CLK_DIV cycles low followed by CLK_DIV cycles high, starting low. The first low half provides CSB setup.
- Output timing: output data changes only when entering a low half (falling edge, or CSB assert).
- Input sampling: qspi_din is sampled on the soc_clk edge on which qspi_clk goes 0->1. It is not synchronised; SCK is slow relative to soc_clk.
- CMD and ADDR phases: qspi_oe=4'b0001. qspi_dout[0] carries the bits MSB first (READ_CMD[7] first, then req_addr[23]). qspi_dout[3:1]=0.
- DUMMY and DATA phases: qspi_oe=4'b0000.
- DATA phase: each rising edge shifts in one nibble from qspi_din[3:0]. The nibble sequence is byte0 high, byte0 low, byte1 high, byte1 low, and so on.
- Completion:
  - After the 8th data SCK period (its high half plus a trailing low half of CLK_DIV cycles), the FSM enters DONE.
  - In DONE: qspi_csb=1, resp_valid=1 for exactly one cycle, and resp_data is updated.
  - resp_data holds its value until the next response.
- Latency: 8+24+DUMMY_CYCLES+8 = 48 SCK periods at defaults. resp_valid fires at cycle accept + 1 + 96*CLK_DIV, which is cycle 193 at CLK_DIV=2.
- Back-to-back requests: req_ready is reasserted CSB_HIGH cycles after the DONE cycle.
- No response backpressure: the consumer must take resp_data on the resp_valid pulse.
- Counter widths:
  - Bit counter: 6 bits, sufficient for 24 address bits.
  - Divider counter: 4 bits.
  - Counters reload on each phase change; none wrap mid-phase.

Decomposition:
- Shared package qspi_pkg holds:
  - the state enum (IDLE, CMD, ADDR, DUMMY, DATA, DONE, GAP);
  - constants QSPI_CMD_QOFR=8'h6B, QSPI_ADDR_BITS=24, QSPI_DATA_NIBBLES=8;
  - the IO-enable encodings OE_SINGLE=4'b0001 and OE_NONE=4'b0000.
- One sub-module, qspi_sck_gen: the divider that produces qspi_clk plus single-cycle rise/fall strobes. Its inputs are enable and start-low; the CLK_DIV parameter is passed through. The FSM advances only on these strobes.

Test Plan:
- Reset released, req_valid=0 -> qspi_csb=1, qspi_clk=0, qspi_oe=0, req_ready=1, resp_valid=0 held for 20 cycles.
- req_addr=24'h00_1234, CLK_DIV=2 -> on rising edges 1-8, IO0 reads 0x6B. On edges 9-32, IO0 reads 0x001234 MSB first. qspi_oe=0001 through edge 32, then 0000.
- Flash model returns bytes 0xEF,0xBE,0xAD,0xDE at data nibbles -> resp_valid is a single pulse at cycle accept+193 with resp_data=32'hDEADBEEF. qspi_csb rises in that same cycle.
- Back-to-back requests, req_valid held high -> second accept occurs exactly CSB_HIGH=4 cycles after the first resp_valid. qspi_csb stays high for at least 4 cycles. The second address is captured correctly.
- rst_n=0 asserted for one cycle during the ADDR phase -> next cycle qspi_csb=1, qspi_clk=0, oe=0, no resp_valid. A subsequent request completes normally.
- CLK_DIV=1 with a new request -> each SCK high and low half lasts 1 cycle. resp_valid at accept+97 with correct data.
